id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode, operand forwarding and ID/EX register.
// Optional macro ILLEGAL_DECODE_EN enables illegal-encoding detection.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic        fwd_mem_we,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic        fwd_wb_we,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [31:0] ex_d1,
  output logic [31:0] ex_d2,
  output logic [3:0]  ex_control,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_is_branch,
  output logic [2:0]  ex_funct3,
  output logic [31:0] ex_store_data,
  output logic        ex_illegal
);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  control;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic [2:0]  funct3;
    logic [31:0] store_data;
    logic        illegal;
  } id_ex_t;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        use1;
  logic        use2;
  logic        load_use;
  logic        bad;
  logic        ex_v;
  id_ex_t      dec;
  id_ex_t      ex_q;

  assign opc   = id_instr[6:0];
  assign rd    = id_instr[11:7];
  assign f3    = id_instr[14:12];
  assign rs1   = id_instr[19:15];
  assign rs2   = id_instr[24:20];
  assign f7    = id_instr[31:25];
  assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
  assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_u = {id_instr[31:12], 12'd0};

  // which source registers the opcode actually reads
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    case (opc)
      OP_R, OP_ST, OP_BR: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      OP_I, OP_LD, OP_JALR: use1 = 1'b1;
      default: ;
    endcase
  end

  // rs1 operand: MEM beats WB beats register file; x0 never forwarded
  always_comb begin
    op1 = id_rs1_data;
    if (use1 && rs1 != 5'd0) begin
      if (fwd_mem_we && fwd_mem_rd == rs1)
        op1 = fwd_mem_data;
      else if (fwd_wb_we && fwd_wb_rd == rs1)
        op1 = fwd_wb_data;
    end
  end

  // rs2 operand, same priority
  always_comb begin
    op2 = id_rs2_data;
    if (use2 && rs2 != 5'd0) begin
      if (fwd_mem_we && fwd_mem_rd == rs2)
        op2 = fwd_mem_data;
      else if (fwd_wb_we && fwd_wb_rd == rs2)
        op2 = fwd_wb_data;
    end
  end

`ifdef ILLEGAL_DECODE_EN
  // flag encodings the datapath does not implement
  always_comb begin
    bad = 1'b0;
    case (opc)
      OP_R:
        bad = (f7 != 7'h00 && f7 != 7'h20) ||
              (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101);
      OP_I:
        if (f3 == 3'b001)
          bad = f7 != 7'h00;
        else if (f3 == 3'b101)
          bad = f7 != 7'h00 && f7 != 7'h20;
      OP_LD, OP_ST, OP_BR, OP_LUI,
      OP_AUI, OP_JAL, OP_JALR: bad = 1'b0;
      default: bad = 1'b1;
    endcase
  end
`else
  assign bad = 1'b0;
`endif

  // decode operands, ALU code and side-band control
  always_comb begin
    dec            = '0;
    dec.rd         = rd;
    dec.funct3     = f3;
    dec.store_data = op2;
    case (opc)
      OP_R: begin
        dec.d1        = op1;
        dec.d2        = op2;
        dec.control   = {id_instr[30], f3};
        dec.reg_write = 1'b1;
      end
      OP_I: begin
        dec.d1        = op1;
        dec.d2        = imm_i;
        dec.control   = {(f3 == 3'b101) & id_instr[30], f3};
        dec.reg_write = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101)
          dec.d2 = {27'd0, rs2};
      end
      OP_LD: begin
        dec.d1        = op1;
        dec.d2        = imm_i;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_ST: begin
        dec.d1        = op1;
        dec.d2        = imm_s;
        dec.mem_write = 1'b1;
      end
      OP_BR: begin
        dec.d1        = op1;
        dec.d2        = op2;
        dec.is_branch = 1'b1;
        if (!f3[2])
          dec.control = 4'b1000;
        else if (f3[1])
          dec.control = 4'b0011;
        else
          dec.control = 4'b0010;
      end
      OP_LUI: begin
        dec.d2        = imm_u;
        dec.reg_write = 1'b1;
      end
      OP_AUI: begin
        dec.d1        = id_pc;
        dec.d2        = imm_u;
        dec.reg_write = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        dec.d1        = id_pc;
        dec.d2        = 32'd4;
        dec.reg_write = 1'b1;
      end
      default: ;
    endcase
    if (rd == 5'd0)
      dec.reg_write = 1'b0;
    if (bad) begin
      dec.illegal   = 1'b1;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
    end
  end

  assign load_use = id_valid && ex_v && ex_q.mem_read &&
                    ex_q.rd != 5'd0 &&
                    ((use1 && rs1 == ex_q.rd) ||
                     (use2 && rs2 == ex_q.rd));

  assign id_ready = ex_ready & ~load_use;

  // EX register: reset, flush/bubble/drain clear, hold, or load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_v <= 1'b0;
      ex_q <= '0;
    end else if (flush ||
                 (ex_ready && (load_use || !id_valid))) begin
      ex_v           <= 1'b0;
      ex_q.reg_write <= 1'b0;
      ex_q.mem_read  <= 1'b0;
      ex_q.mem_write <= 1'b0;
      ex_q.is_branch <= 1'b0;
      ex_q.illegal   <= 1'b0;
    end else if (ex_ready) begin
      ex_v <= 1'b1;
      ex_q <= dec;
    end
  end

  assign ex_valid      = ex_v;
  assign ex_d1         = ex_q.d1;
  assign ex_d2         = ex_q.d2;
  assign ex_control    = ex_q.control;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_is_branch  = ex_q.is_branch;
  assign ex_funct3     = ex_q.funct3;
  assign ex_store_data = ex_q.store_data;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table plus hand sequences for id_ex_stage.
// Build with or without ILLEGAL_DECODE_EN.
module tb_id_ex_stage;

`ifdef ILLEGAL_DECODE_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, id_valid, fwd_mem_we, fwd_wb_we;
  logic        ex_ready, flush;
  logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        id_ready, ex_valid;
  logic [31:0] ex_d1, ex_d2, ex_store_data;
  logic [3:0]  ex_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_is_branch, ex_illegal;
  logic [2:0]  ex_funct3;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd),
    .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd),
    .fwd_wb_data(fwd_wb_data),
    .ex_ready(ex_ready), .flush(flush), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_d1(ex_d1), .ex_d2(ex_d2),
    .ex_control(ex_control), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_is_branch(ex_is_branch),
    .ex_funct3(ex_funct3), .ex_store_data(ex_store_data),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1, d2, sd;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic [3:0]  fl;
    logic [2:0]  f3;
    logic        cf3, csd;
  } exp_t;

  typedef struct {
    logic [31:0] instr, pc, r1, r2, md, wd;
    logic        me, we;
    logic [4:0]  mrd, wrd;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  localparam logic [6:0] OPI = 7'b0010011;

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2, rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [11:0] imm, input logic [4:0] rs2, rs1,
    input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [4:0] rs2, rs1, input logic [2:0] f3);
    return {7'd0, rs2, rs1, f3, 5'd0, 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(
    input logic [19:0] imm, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // fl = {reg_write, mem_read, mem_write, is_branch}
  function automatic void add(
    input logic [31:0] instr, pc, r1, r2,
    input logic me, input logic [4:0] mrd, input logic [31:0] md,
    input logic we, input logic [4:0] wrd, input logic [31:0] wd,
    input logic [31:0] d1, d2, input logic [3:0] ctl,
    input logic [4:0] rd, input logic [3:0] fl,
    input logic [2:0] f3, input logic cf3,
    input logic [31:0] sd, input logic csd);
    vec_t v;
    v.instr = instr; v.pc = pc; v.r1 = r1; v.r2 = r2;
    v.me = me; v.mrd = mrd; v.md = md;
    v.we = we; v.wrd = wrd; v.wd = wd;
    v.e.d1 = d1; v.e.d2 = d2; v.e.ctl = ctl; v.e.rd = rd;
    v.e.fl = fl; v.e.f3 = f3; v.e.cf3 = cf3;
    v.e.sd = sd; v.e.csd = csd;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_instr = v.instr; id_pc = v.pc;
    id_rs1_data = v.r1; id_rs2_data = v.r2;
    fwd_mem_we = v.me; fwd_mem_rd = v.mrd; fwd_mem_data = v.md;
    fwd_wb_we = v.we; fwd_wb_rd = v.wrd; fwd_wb_data = v.wd;
  endtask

  task automatic no_fwd();
    fwd_mem_we = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'd0;
    fwd_wb_we = 1'b0; fwd_wb_rd = 5'd0; fwd_wb_data = 32'd0;
  endtask

  task automatic pop_cmp(input string n);
    exp_t e;
    if (sb.size() == 0) begin
      chk({n, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({n, ".d1"}, ex_d1, e.d1);
    chk({n, ".d2"}, ex_d2, e.d2);
    chk({n, ".ctl"}, 32'(ex_control), 32'(e.ctl));
    chk({n, ".rd"}, 32'(ex_rd), 32'(e.rd));
    chk({n, ".flags"},
        32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch}),
        32'(e.fl));
    chk({n, ".illegal"}, 32'(ex_illegal), 32'd0);
    if (e.cf3) chk({n, ".f3"}, 32'(ex_funct3), 32'(e.f3));
    if (e.csd) chk({n, ".sd"}, ex_store_data, e.sd);
  endtask

  // issue one vector with ex_ready high and expect acceptance
  task automatic apply(input string n, input vec_t v);
    @(negedge clk);
    drive(v);
    id_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0;
    #1;
    chk({n, ".id_ready"}, 32'(id_ready), 32'd1);
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    chk({n, ".ex_valid"}, 32'(ex_valid), 32'd1);
    pop_cmp(n);
  endtask

  vec_t lw, dep, hv;

  initial begin
    rst_n = 1'b0; id_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0;
    id_instr = enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPI);
    id_pc = 32'd0; id_rs1_data = 32'd9; id_rs2_data = 32'd9;
    no_fwd();

    add(enc_i(12'd5, 0, 0, 1, OPI), 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'd0, 32'd5, 4'h0, 5'd1, 4'b1000, 3'd0, 1, 0, 0);
    add(enc_r(7'h20, 2, 1, 0, 3), 0, 32'hdead, 32'd7,
        1, 1, 32'h10, 1, 1, 32'h20,
        32'h10, 32'd7, 4'b1000, 5'd3, 4'b1000, 3'd0, 1, 0, 0);
    add(enc_r(7'h00, 2, 1, 0, 4), 0, 32'd100, 32'd1,
        1, 9, 32'h33, 1, 2, 32'h55,
        32'd100, 32'h55, 4'h0, 5'd4, 4'b1000, 3'd0, 1, 0, 0);
    add(enc_i(12'h403, 7, 5, 7, OPI), 0, 32'h8000_0000, 0,
        0, 0, 0, 0, 0, 0,
        32'h8000_0000, 32'd3, 4'b1101, 5'd7, 4'b1000, 3'd5, 1, 0, 0);
    add(enc_b(2, 1, 3'b110), 0, 32'd5, 32'd9,
        1, 2, 32'h77, 0, 0, 0,
        32'd5, 32'h77, 4'b0011, 5'd0, 4'b0001, 3'd6, 1, 32'h77, 1);
    add(enc_u(20'h12345, 9, 7'b0110111), 0, 0, 0, 0, 0, 0, 0, 0, 0,
        32'd0, 32'h1234_5000, 4'h0, 5'd9, 4'b1000, 3'd0, 0, 0, 0);
    add(enc_u(20'h1, 10, 7'b0010111), 32'h100, 0, 0,
        0, 0, 0, 0, 0, 0,
        32'h100, 32'h1000, 4'h0, 5'd10, 4'b1000, 3'd0, 0, 0, 0);
    add(enc_u(20'h0, 1, 7'b1101111), 32'h200, 0, 0,
        0, 0, 0, 0, 0, 0,
        32'h200, 32'd4, 4'h0, 5'd1, 4'b1000, 3'd0, 0, 0, 0);
    add(enc_s(12'd8, 2, 3, 3'b010), 0, 32'h1000, 32'habc,
        0, 0, 0, 1, 2, 32'h999,
        32'h1000, 32'd8, 4'h0, 5'd8, 4'b0010, 3'd2, 1, 32'h999, 1);
    add(enc_i(12'd1, 1, 0, 0, OPI), 0, 32'd3, 0, 0, 0, 0, 0, 0, 0,
        32'd3, 32'd1, 4'h0, 5'd0, 4'b0000, 3'd0, 1, 0, 0);
    add(enc_i(12'hfff, 6, 3, 5, OPI), 0, 32'd2, 0,
        0, 0, 0, 0, 0, 0,
        32'd2, 32'hffff_ffff, 4'b0011, 5'd5, 4'b1000, 3'd3, 1, 0, 0);
    add(enc_r(7'h00, 10, 0, 4, 8), 0, 32'd0, 32'h5a,
        1, 0, 32'hffff, 0, 0, 0,
        32'd0, 32'h5a, 4'b0100, 5'd8, 4'b1000, 3'd4, 1, 0, 0);
    add(enc_r(7'h00, 4, 3, 1, 2), 0, 32'd6, 32'd2,
        0, 0, 0, 0, 0, 0,
        32'd6, 32'd2, 4'b0001, 5'd2, 4'b1000, 3'd1, 1, 0, 0);
    add(enc_i(12'd0, 6, 0, 1, 7'b1100111), 32'h300, 32'd77, 0,
        0, 0, 0, 0, 0, 0,
        32'h300, 32'd4, 4'h0, 5'd1, 4'b1000, 3'd0, 1, 0, 0);
    add(enc_i(12'hffc, 4, 2, 5, 7'b0000011), 0, 32'h2000, 0,
        0, 0, 0, 0, 0, 0,
        32'h2000, 32'hffff_fffc, 4'h0, 5'd5, 4'b1100, 3'd2, 1, 0, 0);
    lw = tbl[tbl.size()-1];
    dep = lw;
    dep.instr = enc_r(7'h00, 5, 5, 0, 6);
    dep.r1 = 32'd3; dep.r2 = 32'd4;
    dep.e.d1 = 32'd3; dep.e.d2 = 32'd4; dep.e.ctl = 4'h0;
    dep.e.rd = 5'd6; dep.e.fl = 4'b1000; dep.e.f3 = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.ex_valid", 32'(ex_valid), 32'd0);
    chk("rst.d1", ex_d1, 32'd0);
    chk("rst.d2", ex_d2, 32'd0);
    chk("rst.ctl", 32'(ex_control), 32'd0);
    chk("rst.rd", 32'(ex_rd), 32'd0);
    chk("rst.rw", 32'(ex_reg_write), 32'd0);
    chk("rst.illegal", 32'(ex_illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // load-use: one-cycle bubble, then forwarded issue
    @(negedge clk);
    drive(dep);
    id_valid = 1'b1;
    #1;
    chk("lu.id_ready0", 32'(id_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu.bubble_mr", 32'(ex_mem_read), 32'd0);
    chk("lu.bubble_rw", 32'(ex_reg_write), 32'd0);
    @(negedge clk);
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'h1234;
    #1;
    chk("lu.id_ready1", 32'(id_ready), 32'd1);
    hv = dep;
    hv.e.d1 = 32'h1234; hv.e.d2 = 32'h1234;
    sb.push_back(hv.e);
    @(posedge clk);
    #1;
    chk("lu.issue_valid", 32'(ex_valid), 32'd1);
    pop_cmp("lu.issue");

    // hold under back-pressure, then flush while held
    hv = tbl[0];
    hv.instr = enc_i(12'd7, 0, 0, 11, OPI);
    hv.e.d2 = 32'd7; hv.e.rd = 5'd11;
    apply("hold.load", hv);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      id_instr = enc_i(12'd9, 0, 0, 12, OPI);
      id_valid = 1'b1; ex_ready = 1'b0; no_fwd();
      #1;
      chk("hold.id_ready", 32'(id_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("hold.valid", 32'(ex_valid), 32'd1);
      chk("hold.d2", ex_d2, 32'd7);
      chk("hold.rd", 32'(ex_rd), 32'd11);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush.valid", 32'(ex_valid), 32'd0);
    chk("flush.rw", 32'(ex_reg_write), 32'd0);
    @(negedge clk);
    flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle.valid", 32'(ex_valid), 32'd0);

    // unknown opcode and reserved OP funct7/funct3 combination
    @(negedge clk);
    id_instr = 32'h0000_0080; id_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("unk.valid", 32'(ex_valid), 32'd1);
    chk("unk.illegal", 32'(ex_illegal), 32'(ILL));
    chk("unk.flags",
        32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch}),
        32'd0);
    chk("unk.ctl", 32'(ex_control), 32'd0);
    @(negedge clk);
    id_instr = enc_r(7'h20, 2, 1, 3'b001, 3);
    @(posedge clk);
    #1;
    chk("rsv.illegal", 32'(ex_illegal), 32'(ILL));
    chk("rsv.rw", 32'(ex_reg_write), 32'(!ILL));
    if (!ILL) chk("rsv.ctl", 32'(ex_control), 32'h9);

    // reset in the middle of a load-use stall
    apply("rs.lw", lw);
    @(negedge clk);
    drive(dep);
    #1;
    chk("rs.id_ready0", 32'(id_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rs.valid", 32'(ex_valid), 32'd0);
    chk("rs.mr", 32'(ex_mem_read), 32'd0);
    chk("rs.d1", ex_d1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rs.id_ready1", 32'(id_ready), 32'd1);
    apply("rs.reissue", dep);

    chk("sb.drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
